// File: rtl/jstk_pkg.sv
// Shared types and constants for the joystick navigation block.
// Holds direction and FSM state encodings, axis width, default rest value,
// and the counter widths used by the repeat scheduler.
package jstk_pkg;

   localparam int AXIS_W     = 10;   // PmodJSTK axis sample width
   localparam int CENTER_DEF = 512;  // nominal rest value of both axes
   localparam int CNT_W      = 8;    // samples-between-pulses counter width
   localparam int MAG_W      = 4;    // step_mag width

   typedef enum logic [2:0] {
      DIR_NEUTRAL = 3'd0,
      DIR_UP      = 3'd1,
      DIR_DOWN    = 3'd2,
      DIR_LEFT    = 3'd3,
      DIR_RIGHT   = 3'd4
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_REPEAT = 2'd3
   } state_e;

   // Up/down produce step pulses; left/right produce field-select pulses.
   function automatic logic is_step_dir(input dir_e d);
      return (d == DIR_UP) || (d == DIR_DOWN);
   endfunction

endpackage

// File: rtl/jstk_axis_hyst.sv
// Per-axis classifier: signed offset from rest, magnitude, enter/exit compares.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: pos (raw sample) -> mag (|pos-CENTER|), neg (offset sign),
//        enter (mag > DZ_ENTER), keep_pos/keep_neg (deflection still held on
//        that side, mag >= DZ_EXIT with matching sign).
module jstk_axis_hyst
   import jstk_pkg::*;
#(
   parameter int CENTER   = CENTER_DEF,
   parameter int DZ_ENTER = 200,
   parameter int DZ_EXIT  = 120
) (
   input  logic [AXIS_W-1:0] pos,
   output logic [AXIS_W-1:0] mag,
   output logic              neg,
   output logic              enter,
   output logic              keep_pos,
   output logic              keep_neg
);

   localparam logic [AXIS_W:0]   CENTER_C = (AXIS_W+1)'(CENTER);
   localparam logic [AXIS_W-1:0] ENTER_C  = AXIS_W'(DZ_ENTER);
   localparam logic [AXIS_W-1:0] EXIT_C   = AXIS_W'(DZ_EXIT);

   logic signed [AXIS_W:0] off;

   always_comb begin
      off = $signed({1'b0, pos} - CENTER_C);
      neg = off[AXIS_W];
      // Largest magnitude is CENTER itself (pos = 0), which still fits the
      // axis width, so the low bits of the negated offset are exact.
      if (neg) begin
         mag = ~off[AXIS_W-1:0] + 1'b1;
      end else begin
         mag = off[AXIS_W-1:0];
      end
      enter    = (mag > ENTER_C);
      keep_pos = !neg && (mag >= EXIT_C);
      keep_neg =  neg && (mag >= EXIT_C);
   end

endmodule

// File: rtl/jstk_nav.sv
// Joystick navigation: turns PmodJSTK samples into step/select pulses with
// deadzone hysteresis and hold-to-auto-repeat for the stopwatch adjust path.
// Latency: pulses appear 1 cycle after the qualifying sample_vld, 1 cycle wide.
// Backpressure: none; one evaluation per sample_vld cycle (may be stuck high).
// Ports: clk/rst_n (async active-low); sample_vld + pos_x/pos_y sample input;
//        enable = adjust mode; step_inc/step_dec (+ step_mag), sel_next/sel_prev
//        pulses; dir = current classified direction.
// Optional: define JSTK_NAV_ACCEL_EN to emit step_mag=10 after ACCEL_AFTER
//        repeats of a held up/down; otherwise step_mag is constant 1.
module jstk_nav
   import jstk_pkg::*;
#(
   parameter int CENTER   = CENTER_DEF,
   parameter int DZ_ENTER = 200,
   parameter int DZ_EXIT  = 120,
   parameter int INIT_DLY = 3,
   parameter int RPT_DLY  = 1
`ifdef JSTK_NAV_ACCEL_EN
   ,
   parameter int ACCEL_AFTER = 8
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_vld,
   input  logic [AXIS_W-1:0] pos_x,
   input  logic [AXIS_W-1:0] pos_y,
   input  logic              enable,
   output logic              step_inc,
   output logic              step_dec,
   output logic [MAG_W-1:0]  step_mag,
   output logic              sel_next,
   output logic              sel_prev,
   output logic [2:0]        dir
);

   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_DLY);
   localparam logic [CNT_W-1:0] RPT_C  = CNT_W'(RPT_DLY);

   // ------------------------------------------------------------------
   // Per-axis classification
   // ------------------------------------------------------------------
   logic [AXIS_W-1:0] mag_x, mag_y;
   logic              neg_x, neg_y;
   logic              ent_x, ent_y;
   logic              kp_x, kn_x, kp_y, kn_y;

   jstk_axis_hyst #(
      .CENTER   (CENTER),
      .DZ_ENTER (DZ_ENTER),
      .DZ_EXIT  (DZ_EXIT)
   ) u_axis_x (
      .pos      (pos_x),
      .mag      (mag_x),
      .neg      (neg_x),
      .enter    (ent_x),
      .keep_pos (kp_x),
      .keep_neg (kn_x)
   );

   jstk_axis_hyst #(
      .CENTER   (CENTER),
      .DZ_ENTER (DZ_ENTER),
      .DZ_EXIT  (DZ_EXIT)
   ) u_axis_y (
      .pos      (pos_y),
      .mag      (mag_y),
      .neg      (neg_y),
      .enter    (ent_y),
      .keep_pos (kp_y),
      .keep_neg (kn_y)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e           state_q, state_d;
   dir_e             dir_q,   dir_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             armed_q, armed_d;
   logic             inc_q,   inc_d;
   logic             dec_q,   dec_d;
   logic             next_q,  next_d;
   logic             prev_q,  prev_d;

`ifdef JSTK_NAV_ACCEL_EN
   localparam logic [MAG_W-1:0] ACCEL_C = MAG_W'(ACCEL_AFTER);
   logic [MAG_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [MAG_W-1:0] step_mag_q, step_mag_d;
`endif

   dir_e new_dir;
   logic fire;

   // Direction resolution. An existing deflection wins while its own axis
   // stays past the exit threshold on the same side, even if the other axis
   // is further out; only then do the enter thresholds pick a new direction.
   always_comb begin
      new_dir = DIR_NEUTRAL;
      if ((dir_q == DIR_UP    && kp_y) ||
          (dir_q == DIR_DOWN  && kn_y) ||
          (dir_q == DIR_LEFT  && kn_x) ||
          (dir_q == DIR_RIGHT && kp_x)) begin
         new_dir = dir_q;
      end else if (ent_y && (!ent_x || (mag_y >= mag_x))) begin
         if (neg_y) new_dir = DIR_DOWN;
         else       new_dir = DIR_UP;
      end else if (ent_x) begin
         if (neg_x) new_dir = DIR_LEFT;
         else       new_dir = DIR_RIGHT;
      end
   end

   // Next-state and pulse decode.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      fire    = 1'b0;
`ifdef JSTK_NAV_ACCEL_EN
      rpt_cnt_d  = rpt_cnt_q;
      step_mag_d = step_mag_q;
`endif

      // dir tracks every sample, including while adjust mode is off.
      if (sample_vld) dir_d = new_dir;

      if (!enable) begin
         // Leaving adjust mode parks the FSM without waiting for a sample;
         // nothing is fired, so a pulse due on this sample is dropped.
         state_d = ST_HOLD;
         cnt_d   = '0;
         armed_d = 1'b0;
`ifdef JSTK_NAV_ACCEL_EN
         rpt_cnt_d = '0;
`endif
      end else if (sample_vld) begin
         if (new_dir == DIR_NEUTRAL) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            armed_d = 1'b1;
`ifdef JSTK_NAV_ACCEL_EN
            rpt_cnt_d = '0;
`endif
         end else if (state_q == ST_IDLE || state_q == ST_HOLD) begin
            // Without arming, a stick held since mode entry stays silent
            // until it has been seen at rest.
            state_d = ST_IDLE;
            if (armed_q) begin
               fire    = 1'b1;
               state_d = ST_FIRST;
               cnt_d   = '0;
            end
`ifdef JSTK_NAV_ACCEL_EN
            rpt_cnt_d = '0;
`endif
         end else if (new_dir != dir_q) begin
            // Direct swing to another direction: restart with its first pulse.
            fire    = 1'b1;
            state_d = ST_FIRST;
            cnt_d   = '0;
`ifdef JSTK_NAV_ACCEL_EN
            rpt_cnt_d = '0;
`endif
         end else if (state_q == ST_FIRST) begin
            if (cnt_q == INIT_C) begin
               fire    = 1'b1;
               state_d = ST_REPEAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == RPT_C) begin
               fire  = 1'b1;
               cnt_d = '0;
`ifdef JSTK_NAV_ACCEL_EN
               if (rpt_cnt_q != '1) rpt_cnt_d = rpt_cnt_q + 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

`ifdef JSTK_NAV_ACCEL_EN
      if (!enable) begin
         step_mag_d = MAG_W'(1);
      end else if (sample_vld) begin
         if (is_step_dir(new_dir) && (rpt_cnt_d >= ACCEL_C)) step_mag_d = MAG_W'(10);
         else                                                 step_mag_d = MAG_W'(1);
      end
`endif

      // Only one direction is ever current, so the pulses are exclusive.
      inc_d  = fire && (new_dir == DIR_UP);
      dec_d  = fire && (new_dir == DIR_DOWN);
      next_d = fire && (new_dir == DIR_RIGHT);
      prev_d = fire && (new_dir == DIR_LEFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_NEUTRAL;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         next_q  <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         next_q  <= next_d;
         prev_q  <= prev_d;
      end
   end

`ifdef JSTK_NAV_ACCEL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt_q  <= '0;
         step_mag_q <= MAG_W'(1);
      end else begin
         rpt_cnt_q  <= rpt_cnt_d;
         step_mag_q <= step_mag_d;
      end
   end
   assign step_mag = step_mag_q;
`else
   assign step_mag = MAG_W'(1);
`endif

   assign step_inc = inc_q;
   assign step_dec = dec_q;
   assign sel_next = next_q;
   assign sel_prev = prev_q;
   assign dir      = dir_q;

endmodule

// File: tb/tb_jstk_nav.sv
// Testbench for jstk_nav: directed vector table, hand-written corner cases
// (async reset mid-repeat, enable drop) and randomized stimulus against a
// reference model expressed as a sample-count schedule.
module tb_jstk_nav;

   localparam int CTR      = 512;
   localparam int DZ_ENTER = 200;
   localparam int DZ_EXIT  = 120;
   localparam int INIT_DLY = 3;
   localparam int RPT_DLY  = 1;
`ifdef JSTK_NAV_ACCEL_EN
   localparam int ACCEL_AFTER = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_vld;
   logic       enable;
   logic [9:0] pos_x, pos_y;
   logic       step_inc, step_dec, sel_next, sel_prev;
   logic [3:0] step_mag;
   logic [2:0] dir;

   jstk_nav u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_vld (sample_vld),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .enable     (enable),
      .step_inc   (step_inc),
      .step_dec   (step_dec),
      .step_mag   (step_mag),
      .sel_next   (sel_next),
      .sel_prev   (sel_prev),
      .dir        (dir)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model. A held direction is tracked as k = number of
   // same-direction samples since its first pulse; pulses fall at k = 0,
   // k = INIT_DLY+1, then every RPT_DLY+1 samples after that.
   // ------------------------------------------------------------------
   int         m_dir, m_armed, m_chain, m_k;
   logic [3:0] exp_p;     // {inc, dec, next, prev}
   int         exp_mag;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int classify(input int x, input int y, input int cur);
      int dx, dy, ax, ay;
      dx = x - CTR;
      dy = y - CTR;
      ax = iabs(dx);
      ay = iabs(dy);
      if (cur == 1 && dy >=  DZ_EXIT) return 1;
      if (cur == 2 && -dy >= DZ_EXIT) return 2;
      if (cur == 3 && -dx >= DZ_EXIT) return 3;
      if (cur == 4 && dx >=  DZ_EXIT) return 4;
      if (ay > DZ_ENTER && (ay >= ax || ax <= DZ_ENTER)) return (dy > 0) ? 1 : 2;
      if (ax > DZ_ENTER) return (dx > 0) ? 4 : 3;
      return 0;
   endfunction

   function automatic bit scheduled(input int k);
      if (k == INIT_DLY + 1) return 1'b1;
      if (k > INIT_DLY + 1 && ((k - INIT_DLY - 1) % (RPT_DLY + 1)) == 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_dir = 0; m_armed = 0; m_chain = 0; m_k = 0;
   endtask

   task automatic model_step(input bit en, input bit vld, input int x, input int y);
      int nd;
      bit fire;
      exp_p   = 4'b0000;
      exp_mag = 1;
      fire    = 1'b0;
      if (!en) begin
         m_armed = 0;
         m_chain = 0;
         if (vld) m_dir = classify(x, y, m_dir);
      end else if (vld) begin
         nd = classify(x, y, m_dir);
         if (nd == 0) begin
            m_chain = 0;
            m_armed = 1;
         end else if (m_chain == 0) begin
            if (m_armed != 0) begin
               fire = 1'b1; m_chain = 1; m_k = 0;
            end
         end else if (nd != m_dir) begin
            fire = 1'b1; m_k = 0;
         end else begin
            m_k++;
            fire = scheduled(m_k);
         end
         m_dir = nd;
         if (fire) begin
            case (nd)
               1: exp_p = 4'b1000;
               2: exp_p = 4'b0100;
               4: exp_p = 4'b0010;
               default: exp_p = 4'b0001;
            endcase
`ifdef JSTK_NAV_ACCEL_EN
            if ((nd == 1 || nd == 2) && m_k >= INIT_DLY + 1 &&
                ((m_k - INIT_DLY - 1) / (RPT_DLY + 1)) >= ACCEL_AFTER)
               exp_mag = 10;
`endif
         end
      end
   endtask

   // One clock of stimulus, compared against the model after the edge.
   task automatic cyc(input bit en, input bit vld, input int x, input int y, input string tag);
      enable     = en;
      sample_vld = vld;
      pos_x      = 10'(x);
      pos_y      = 10'(y);
      model_step(en, vld, x, y);
      @(posedge clk); #1;
      chk({tag, "_out"}, int'({step_inc, step_dec, sel_next, sel_prev, dir}),
          int'({exp_p, 3'(m_dir)}));
      if (exp_p[3] || exp_p[2]) chk({tag, "_mag"}, int'(step_mag), exp_mag);
      chk({tag, "_excl"}, int'($countones({step_inc, step_dec, sel_next, sel_prev}) <= 1), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; sample_vld = 1'b0;
      pos_x = 10'd512; pos_y = 10'd512;
      @(posedge clk); #1;
      chk("reset_out", int'({step_inc, step_dec, sel_next, sel_prev, dir}), 0);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------
   typedef struct {
      bit         en;
      bit         vld;
      int         x;
      int         y;
      logic [3:0] ep;   // {inc, dec, next, prev}
      logic [2:0] ed;
   } vec_t;

   localparam int NV = 42;
   vec_t tbl [NV];

   function automatic vec_t mk(input bit en, input bit vld, input int x, input int y,
                               input logic [3:0] ep, input logic [2:0] ed);
      vec_t v;
      v.en = en; v.vld = vld; v.x = x; v.y = y; v.ep = ep; v.ed = ed;
      return v;
   endfunction

   int pts [14] = '{0, 100, 200, 311, 312, 392, 393, 512, 631, 632, 700, 712, 713, 1023};

   function automatic int pick();
      case ($urandom % 4)
         0:       return CTR;
         1:       return int'($urandom % 1024);
         default: return pts[$urandom % 14];
      endcase
   endfunction

   initial begin
      int n_dec, n10;

      // single tap
      tbl[0]  = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      tbl[1]  = mk(1, 1, 512, 800, 4'b1000, 3'd1);
      tbl[2]  = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      // hold down for 10 samples: pulses on samples 1, 5, 7, 9
      tbl[3]  = mk(1, 1, 512, 100, 4'b0100, 3'd2);
      tbl[4]  = mk(1, 1, 512, 100, 4'b0000, 3'd2);
      tbl[5]  = mk(1, 1, 512, 100, 4'b0000, 3'd2);
      tbl[6]  = mk(1, 1, 512, 100, 4'b0000, 3'd2);
      tbl[7]  = mk(1, 1, 512, 100, 4'b0100, 3'd2);
      tbl[8]  = mk(1, 1, 512, 100, 4'b0000, 3'd2);
      tbl[9]  = mk(1, 1, 512, 100, 4'b0100, 3'd2);
      tbl[10] = mk(1, 1, 512, 100, 4'b0000, 3'd2);
      tbl[11] = mk(1, 1, 512, 100, 4'b0100, 3'd2);
      tbl[12] = mk(1, 1, 512, 100, 4'b0000, 3'd2);
      tbl[13] = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      // no strobe: position ignored
      tbl[14] = mk(1, 0, 900, 900, 4'b0000, 3'd0);
      // hysteresis on Y
      tbl[15] = mk(1, 1, 512, 750, 4'b1000, 3'd1);
      tbl[16] = mk(1, 1, 512, 650, 4'b0000, 3'd1);
      tbl[17] = mk(1, 1, 512, 640, 4'b0000, 3'd1);
      tbl[18] = mk(1, 1, 512, 700, 4'b0000, 3'd1);
      tbl[19] = mk(1, 1, 512, 600, 4'b0000, 3'd0);
      // arming and priority
      tbl[20] = mk(0, 1, 900, 512, 4'b0000, 3'd4);
      tbl[21] = mk(1, 1, 900, 512, 4'b0000, 3'd4);
      tbl[22] = mk(1, 1, 900, 512, 4'b0000, 3'd4);
      tbl[23] = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      tbl[24] = mk(1, 1, 900, 880, 4'b0010, 3'd4);
      tbl[25] = mk(1, 1, 512, 900, 4'b1000, 3'd1);
      tbl[26] = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      // left
      tbl[27] = mk(1, 1, 100, 512, 4'b0001, 3'd3);
      tbl[28] = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      // equal magnitudes: Y wins
      tbl[29] = mk(1, 1, 900, 900, 4'b1000, 3'd1);
      tbl[30] = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      // thresholds: 200 does not enter, 201 does; 120 holds, 119 releases
      tbl[31] = mk(1, 1, 512, 712, 4'b0000, 3'd0);
      tbl[32] = mk(1, 1, 512, 713, 4'b1000, 3'd1);
      tbl[33] = mk(1, 1, 512, 632, 4'b0000, 3'd1);
      tbl[34] = mk(1, 1, 512, 631, 4'b0000, 3'd0);
      // up to down without a neutral gap
      tbl[35] = mk(1, 1, 512, 800, 4'b1000, 3'd1);
      tbl[36] = mk(1, 1, 512, 200, 4'b0100, 3'd2);
      tbl[37] = mk(1, 1, 512, 512, 4'b0000, 3'd0);
      // held axis beats a larger other axis until it drops below exit
      tbl[38] = mk(1, 1, 512, 800, 4'b1000, 3'd1);
      tbl[39] = mk(1, 1, 1000, 700, 4'b0000, 3'd1);
      tbl[40] = mk(1, 1, 1000, 600, 4'b0010, 3'd4);
      tbl[41] = mk(1, 1, 512, 512, 4'b0000, 3'd0);

      rst_n = 1'b0; enable = 1'b0; sample_vld = 1'b0;
      pos_x = 10'd512; pos_y = 10'd512;
      #1;
      chk("rst_pulses", int'({step_inc, step_dec, sel_next, sel_prev}), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_mag", int'(step_mag), 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         enable     = tbl[i].en;
         sample_vld = tbl[i].vld;
         pos_x      = 10'(tbl[i].x);
         pos_y      = 10'(tbl[i].y);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pulses", i), int'({step_inc, step_dec, sel_next, sel_prev}),
             int'(tbl[i].ep));
         chk($sformatf("vec%0d_dir", i), int'(dir), int'(tbl[i].ed));
         chk($sformatf("vec%0d_mag", i), int'(step_mag), 1);
      end

      // Async reset in the middle of a repeat run, with a pulse showing.
      do_reset();
      cyc(1, 1, 512, 512, "ar_arm");
      n_dec = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(1, 1, 512, 100, "ar_hold");
         if (step_dec) n_dec++;
      end
      chk("ar_pulses_before", n_dec, 3);
      rst_n = 1'b0;
      #1;
      chk("ar_async_out", int'({step_inc, step_dec, sel_next, sel_prev, dir}), 0);
      chk("ar_async_mag", int'(step_mag), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      for (int i = 0; i < 3; i++) cyc(1, 1, 512, 100, "ar_unarmed");
      cyc(1, 1, 512, 512, "ar_rearm");
      cyc(1, 1, 512, 100, "ar_fresh");
      chk("ar_fresh_dec", int'(step_dec), 1);

      // Enable dropped on the sample that would have repeated.
      for (int i = 0; i < 3; i++) cyc(1, 1, 512, 100, "en_hold");
      cyc(0, 1, 512, 100, "en_drop");
      chk("en_drop_suppressed", int'(step_dec), 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 512, 100, "en_back");
      cyc(1, 1, 512, 512, "en_rearm");
      cyc(1, 1, 512, 100, "en_first");
      // Enable low for a cycle with no sample still parks the FSM.
      cyc(0, 0, 512, 100, "en_nosample");
      cyc(1, 1, 512, 100, "en_after_nosample");
      chk("en_nosample_quiet", int'(step_dec), 0);

`ifdef JSTK_NAV_ACCEL_EN
      cyc(1, 1, 512, 512, "acc_arm");
      n10 = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1, 1, 512, 950, "acc_hold");
         if (step_inc && step_mag == 4'd10) n10++;
      end
      chk("acc_n10", n10, 3);
      cyc(1, 1, 512, 512, "acc_release");
      chk("acc_release_mag", int'(step_mag), 1);
`else
      n10 = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1, 1, 512, 950, "mag_hold");
         if (step_mag != 4'd1) n10++;
      end
      chk("mag_const", n10, 0);
`endif

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 20) != 0, ($urandom % 4) != 0, pick(), pick(), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
